// File: rtl/mcse_sha_padder.sv
// mcse_sha_padder
//   Collects 32-bit big-endian message words into a 16-word block buffer,
//   applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit length),
//   hands each 512-bit block to a SHA core with an init/next pulse, and
//   latches the core's final digest.
//
//   Optional feature macro: MCSE_SHA_PAD_TIMEOUT_EN
//     defined   : a cycle counter bounds the time spent waiting on the core
//                 (ISSUE + WAIT); reaching TIMEOUT_CYCLES aborts the message
//                 and sets the sticky error flag.
//     undefined : no counter, error is constant 0, the core is waited on
//                 indefinitely.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   msg_word/valid/last   message word stream (bits [31:24] = first byte)
//   msg_last_bytes        valid bytes in the final word minus 1
//   msg_ready             word accepted when msg_valid && msg_ready
//   sha_block             padded block, word 0 at [511:480]
//   sha_init / sha_next   one-cycle start pulses (first / later blocks)
//   sha_ready, sha_digest SHA core status and result
//   digest, digest_valid  latched final digest and its update pulse
//   busy, error           not-idle indicator, sticky timeout flag
module mcse_sha_padder #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  msg_word,
  input  logic         msg_valid,
  input  logic         msg_last,
  input  logic [1:0]   msg_last_bytes,
  output logic         msg_ready,
  output logic [511:0] sha_block,
  output logic         sha_init,
  output logic         sha_next,
  input  logic         sha_ready,
  input  logic [255:0] sha_digest,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_PAD, S_LEN, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    widx_q, widx_d;
  logic [63:0]   len_q, len_d;
  logic [31:0]   blk_q [16];
  logic [31:0]   blk_d [16];
  logic [511:0]  sha_block_q, sha_block_d;
  logic          sha_init_q, sha_init_d;
  logic          sha_next_q, sha_next_d;
  logic [255:0]  digest_q, digest_d;
  logic          digest_valid_q, digest_valid_d;
  logic          final_q, final_d;         // final word of the message taken
  logic          pad2_q, pad2_d;           // an extra padding block is pending
  logic          mark_next_q, mark_next_d; // 0x80 marker spills into next block
  logic          last_blk_q, last_blk_d;   // block in flight carries the length
  logic          first_q, first_d;         // next issue is the first block
  logic          wait_first_q, wait_first_d;
  logic          accept;
  logic          timeout_hit;
  logic [3:0]    idx;
  logic [63:0]   len_base;
  logic [2:0]    nbytes;

  // Keep the valid bytes of the final word, place 0x80 right after them and
  // clear whatever follows. A full final word gets its marker in the next word.
  function automatic logic [31:0] mark_word(input logic [31:0] w, input logic [1:0] lb);
    case (lb)
      2'd0:    mark_word = {w[31:24], 24'h80_0000};
      2'd1:    mark_word = {w[31:16], 16'h8000};
      2'd2:    mark_word = {w[31:8], 8'h80};
      default: mark_word = w;
    endcase
  endfunction

  assign msg_ready    = (state_q == S_IDLE) || ((state_q == S_FILL) && !final_q);
  assign accept       = msg_valid && msg_ready;
  assign busy         = (state_q != S_IDLE);
  assign sha_block    = sha_block_q;
  assign sha_init     = sha_init_q;
  assign sha_next     = sha_next_q;
  assign digest       = digest_q;
  assign digest_valid = digest_valid_q;

`ifdef MCSE_SHA_PAD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            error_q, error_d;

  // The count runs continuously across ISSUE and WAIT of one block and
  // restarts whenever the FSM is elsewhere.
  always_comb begin
    to_cnt_d    = '0;
    timeout_hit = 1'b0;
    error_d     = error_q;
    if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      if (to_cnt_q == TO_LAST) begin
        timeout_hit = 1'b1;
        error_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      error_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      error_q  <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  // Constant 0 in this build; the wait for sha_ready is unbounded.
  assign error = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d        = state_q;
    widx_d         = widx_q;
    len_d          = len_q;
    blk_d          = blk_q;
    sha_block_d    = sha_block_q;
    sha_init_d     = 1'b0;
    sha_next_d     = 1'b0;
    digest_d       = digest_q;
    digest_valid_d = 1'b0;
    final_d        = final_q;
    pad2_d         = pad2_q;
    mark_next_d    = mark_next_q;
    last_blk_d     = last_blk_q;
    first_d        = first_q;
    wait_first_d   = 1'b0;
    // A new message always starts at word 0 with a zero length, whatever an
    // aborted message left behind.
    idx            = (state_q == S_IDLE) ? 4'd0 : widx_q;
    len_base       = (state_q == S_IDLE) ? 64'd0 : len_q;
    nbytes         = {1'b0, msg_last_bytes} + 3'd1;

    if (accept) begin
      if (state_q == S_IDLE) begin
        final_d     = 1'b0;
        pad2_d      = 1'b0;
        mark_next_d = 1'b0;
        last_blk_d  = 1'b0;
        first_d     = 1'b1;
      end
      if (msg_last) begin
        blk_d[idx] = mark_word(msg_word, msg_last_bytes);
        len_d      = len_base + {58'd0, nbytes, 3'd0};
        final_d    = 1'b1;
        widx_d     = idx + 4'd1;
        if (msg_last_bytes == 2'd3) begin
          if (idx == 4'd15) begin
            mark_next_d = 1'b1;
          end else begin
            blk_d[idx + 4'd1] = 32'h8000_0000;
            widx_d            = idx + 4'd2;
          end
        end
        state_d = (state_q == S_IDLE) ? S_FILL : S_PAD;
      end else begin
        blk_d[idx] = msg_word;
        len_d      = len_base + 64'd32;
        widx_d     = idx + 4'd1;
        state_d    = (idx == 4'd15) ? S_ISSUE : S_FILL;
      end
    end

    case (state_q)
      S_FILL: if (final_q) state_d = S_PAD;
      S_PAD: begin
        if (pad2_q) begin
          // Trailing block: zeros, plus the marker if it spilled over.
          for (int i = 0; i < 16; i++) blk_d[i] = '0;
          if (mark_next_q) blk_d[0] = 32'h8000_0000;
          pad2_d      = 1'b0;
          mark_next_d = 1'b0;
          state_d     = S_LEN;
        end else if (widx_q == 4'd0) begin
          // Data and marker filled all 16 words (widx wrapped).
          pad2_d  = 1'b1;
          state_d = S_ISSUE;
        end else if (widx_q == 4'd15) begin
          // Marker sits in word 14: no room for the length.
          blk_d[15] = '0;
          pad2_d    = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          for (int i = 0; i < 14; i++) begin
            if (4'(i) >= widx_q) blk_d[i] = '0;
          end
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        blk_d[14]  = len_q[63:32];
        blk_d[15]  = len_q[31:0];
        last_blk_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (sha_ready) begin
          for (int i = 0; i < 16; i++) sha_block_d[511 - 32*i -: 32] = blk_q[i];
          sha_init_d   = first_q;
          sha_next_d   = !first_q;
          first_d      = 1'b0;
          wait_first_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        // The core may still report ready in the cycle of the start pulse.
        if (!wait_first_q && sha_ready) begin
          if (last_blk_q)  state_d = S_DONE;
          else if (pad2_q) state_d = S_PAD;
          else             state_d = S_FILL;
        end
      end
      S_DONE: begin
        digest_d       = sha_digest;
        digest_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: ;
    endcase

    if (timeout_hit) begin
      state_d    = S_IDLE;
      sha_init_d = 1'b0;
      sha_next_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      widx_q         <= '0;
      len_q          <= '0;
      for (int i = 0; i < 16; i++) blk_q[i] <= '0;
      sha_block_q    <= '0;
      sha_init_q     <= 1'b0;
      sha_next_q     <= 1'b0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
      final_q        <= 1'b0;
      pad2_q         <= 1'b0;
      mark_next_q    <= 1'b0;
      last_blk_q     <= 1'b0;
      first_q        <= 1'b0;
      wait_first_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      widx_q         <= widx_d;
      len_q          <= len_d;
      blk_q          <= blk_d;
      sha_block_q    <= sha_block_d;
      sha_init_q     <= sha_init_d;
      sha_next_q     <= sha_next_d;
      digest_q       <= digest_d;
      digest_valid_q <= digest_valid_d;
      final_q        <= final_d;
      pad2_q         <= pad2_d;
      mark_next_q    <= mark_next_d;
      last_blk_q     <= last_blk_d;
      first_q        <= first_d;
      wait_first_q   <= wait_first_d;
    end
  end

endmodule

// File: tb/tb_mcse_sha_padder.sv
// Bench for mcse_sha_padder: a reference SHA-256 padding model produces the
// expected blocks of each message, a small core model answers init/next with
// a programmable latency, and a scoreboard pops expectations as the DUT
// emits blocks and digests.
module tb_mcse_sha_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  msg_word;
  logic         msg_valid;
  logic         msg_last;
  logic [1:0]   msg_last_bytes;
  logic         msg_ready;
  logic [511:0] sha_block;
  logic         sha_init;
  logic         sha_next;
  logic         sha_ready;
  logic [255:0] sha_digest;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic         error;

  always #5 clk = ~clk;

  mcse_sha_padder #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .msg_word(msg_word), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_last_bytes(msg_last_bytes), .msg_ready(msg_ready),
    .sha_block(sha_block), .sha_init(sha_init), .sha_next(sha_next),
    .sha_ready(sha_ready), .sha_digest(sha_digest), .digest(digest),
    .digest_valid(digest_valid), .busy(busy), .error(error)
  );

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  typedef struct {
    int         n;      // message length in bytes
    logic [7:0] seed;   // byte k of the message is seed + k
    int         lat;    // core latency in cycles
    int         nblk;   // blocks the DUT must issue
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [511:0] exp_blk_q[$];
  bit           exp_first_q[$];
  logic [255:0] exp_dig_q[$];

  int           pulses = 0;
  int           nexts = 0;
  int           dvs = 0;
  int           core_cnt = 0;
  int           core_lat = 4;
  bit           core_stall = 1'b0;
  bit           skip_hold = 1'b0;
  logic [511:0] held_blk = '0;
  logic [511:0] first_blk = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen with nothing expected", name);
  endtask

  // Core model and scoreboard, sampled on the falling edge.
  initial begin
    sha_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (sha_init || sha_next) begin
        pulses++;
        if (sha_next) nexts++;
        if (sha_init) first_blk = sha_block;
        if (exp_blk_q.size() == 0) begin
          fail_evt("unexpected_block");
        end else begin
          check("block", sha_block, exp_blk_q.pop_front());
          check("init_vs_next", {511'd0, sha_init}, {511'd0, exp_first_q.pop_front()});
        end
        held_blk  = sha_block;
        skip_hold = 1'b0;
        core_cnt  = core_lat;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0 && !skip_hold) check("block_hold", sha_block, held_blk);
      end
      sha_ready = !core_stall && (core_cnt == 0);
      if (digest_valid) begin
        dvs++;
        if (exp_dig_q.size() == 0) fail_evt("unexpected_digest_valid");
        else check("digest", {256'd0, digest}, {256'd0, exp_dig_q.pop_front()});
      end
    end
  end

  // Reference padding: bytes, 0x80, zeros, 64-bit big-endian bit length.
  task automatic push_expect(input int n, input logic [7:0] seed, input logic [255:0] dig);
    logic [7:0]   pb [0:319];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           total;
    total = ((n + 8) / 64 + 1) * 64;
    for (int i = 0; i < total; i++)
      pb[i] = (i < n) ? seed + 8'(i) : ((i == n) ? 8'h80 : 8'h00);
    bits = 64'(n) * 64'd8;
    for (int j = 0; j < 8; j++) pb[total - 8 + j] = bits[63 - 8*j -: 8];
    for (int b = 0; b < total / 64; b++) begin
      for (int k = 0; k < 64; k++) blk[511 - 8*k -: 8] = pb[64*b + k];
      exp_blk_q.push_back(blk);
      exp_first_q.push_back(b == 0);
    end
    exp_dig_q.push_back(dig);
  endtask

  // Drive the message as words; bytes past the end carry 'fill'.
  task automatic drive_msg(input int n, input logic [7:0] seed, input logic [7:0] fill);
    int         nw;
    int         guard;
    logic       rdy;
    logic [31:0] w32;
    nw = (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      if ($urandom_range(0, 3) == 0) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      for (int j = 0; j < 4; j++)
        w32[31 - 8*j -: 8] = (4*w + j < n) ? seed + 8'(4*w + j) : fill;
      msg_word       = w32;
      msg_valid      = 1'b1;
      msg_last       = (w == nw - 1);
      msg_last_bytes = (w == nw - 1) ? 2'((n - 1) % 4) : 2'(w);
      guard = 0;
      forever begin
        rdy = msg_ready;
        @(negedge clk);
        if (rdy) break;
        guard++;
        if (guard > 2000) begin
          fail_evt("msg_ready_timeout");
          msg_valid = 1'b0;
          msg_last  = 1'b0;
          return;
        end
      end
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int g;
    d0 = dvs;
    g  = 0;
    while (dvs == d0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check(name, {511'd0, dvs != d0}, 512'd1);
  endtask

  task automatic run_vec(input vec_t v, input logic [255:0] dig);
    int p0;
    int x0;
    core_lat   = v.lat;
    sha_digest = dig;
    p0 = pulses;
    x0 = nexts;
    push_expect(v.n, v.seed, dig);
    drive_msg(v.n, v.seed, 8'hEE);
    wait_done("digest_valid_seen");
    check("num_blocks", 512'(pulses - p0), 512'(v.nblk));
    check("num_next", 512'(nexts - x0), 512'(v.nblk - 1));
    repeat (2) @(negedge clk);
    check("digest_hold", {256'd0, digest}, {256'd0, dig});
    check("idle_after", {510'd0, busy, msg_ready}, 512'd1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, {511'd0, busy}, 512'd0);
    check({tag, "_msg_ready"}, {511'd0, msg_ready}, 512'd1);
    check({tag, "_pulses"}, {510'd0, sha_init, sha_next}, 512'd0);
    check({tag, "_sha_block"}, sha_block, 512'd0);
    check({tag, "_digest"}, {256'd0, digest}, 512'd0);
    check({tag, "_digest_valid"}, {511'd0, digest_valid}, 512'd0);
    check({tag, "_error"}, {511'd0, error}, 512'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    vec_t v;
    int   g;
    int   p0;
    vecs[0]  = '{1,   8'h10, 3, 1};
    vecs[1]  = '{4,   8'h20, 1, 1};
    vecs[2]  = '{5,   8'h30, 2, 1};
    vecs[3]  = '{8,   8'h40, 7, 1};
    vecs[4]  = '{55,  8'h01, 4, 1};
    vecs[5]  = '{56,  8'h02, 5, 2};
    vecs[6]  = '{59,  8'h03, 3, 2};
    vecs[7]  = '{60,  8'h04, 6, 2};
    vecs[8]  = '{63,  8'h05, 2, 2};
    vecs[9]  = '{64,  8'h06, 8, 2};
    vecs[10] = '{65,  8'h07, 4, 2};
    vecs[11] = '{120, 8'h08, 3, 3};
    vecs[12] = '{128, 8'h09, 5, 3};

    rst            = 1'b1;
    msg_word       = '0;
    msg_valid      = 1'b0;
    msg_last       = 1'b0;
    msg_last_bytes = '0;
    sha_digest     = '0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // "abc": one block 0x61626380, zeros, length 0x18.
    core_lat   = 5;
    sha_digest = ABC_DIGEST;
    p0 = pulses;
    push_expect(3, 8'h61, ABC_DIGEST);
    drive_msg(3, 8'h61, 8'h00);
    wait_done("abc_done");
    check("abc_blocks", 512'(pulses - p0), 512'd1);
    check("abc_word0", {480'd0, first_blk[511:480]}, {480'd0, 32'h6162_6380});
    check("abc_word15", {480'd0, first_blk[31:0]}, {480'd0, 32'h0000_0018});
    check("abc_digest", {256'd0, digest}, {256'd0, ABC_DIGEST});

    for (int i = 0; i < 13; i++)
      run_vec(vecs[i], {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()});

    // Reset while the first block of a two-block message is with the core.
    core_lat   = 9;
    sha_digest = {8{32'hDEAD_BEEF}};
    p0 = pulses;
    push_expect(56, 8'h55, sha_digest);
    drive_msg(56, 8'h55, 8'hEE);
    g = 0;
    while (pulses == p0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("rst_first_issue", {511'd0, pulses != p0}, 512'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_blk_q.delete();
    exp_first_q.delete();
    exp_dig_q.delete();
    skip_hold = 1'b1;
    check_cleared("midmsg_rst");
    repeat (12) @(negedge clk);
    v = '{60, 8'h77, 4, 2};
    run_vec(v, {8{32'h0123_4567}});

`ifdef MCSE_SHA_PAD_TIMEOUT_EN
    // Core never ready: abort after 16 cycles in ISSUE/WAIT.
    core_stall = 1'b1;
    @(negedge clk);
    p0 = dvs;
    drive_msg(4, 8'h42, 8'hEE);
    g = 0;
    while (!error && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("timeout_error", {511'd0, error}, 512'd1);
    check("timeout_latency", {511'd0, (g >= 16 && g <= 22)}, 512'd1);
    check("timeout_busy", {511'd0, busy}, 512'd0);
    check("timeout_msg_ready", {511'd0, msg_ready}, 512'd1);
    repeat (3) @(negedge clk);
    check("timeout_no_digest", 512'(dvs - p0), 512'd0);
    check("timeout_sticky", {511'd0, error}, 512'd1);
    core_stall = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("timeout_rst_error", {511'd0, error}, 512'd0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
